// File: rtl/fp_scoreboard.sv
// FP scoreboard: tracks in-flight multi-cycle FPU ops, flags RAW hazards on sources, retires results in slot order.
// Optional macro FP_SCOREBOARD_WAW_CHECK_EN additionally stalls issue while the destination is already pending.
module fp_scoreboard #(
    parameter int NSLOTS = 4,
    parameter int LAT_W  = 5
) (
    input  logic                           clk,
    input  logic                           Rst,
    input  logic                           flush,
    input  logic                           iss_valid,
    output logic                           iss_ready,
    input  logic [4:0]                     iss_rd,
    input  logic                           iss_rd_fp,
    input  logic [LAT_W-1:0]               iss_lat,
    input  logic [4:0]                     rs1,
    input  logic [4:0]                     rs2,
    input  logic [4:0]                     rs3,
    input  logic                           rs1_fp,
    input  logic                           rs2_fp,
    input  logic                           rs3_fp,
    input  logic [2:0]                     rs_used,
    output logic                           hz,
    output logic                           wb_valid,
    output logic [4:0]                     wb_rd,
    output logic                           wb_fp,
    input  logic                           wb_ready,
    output logic [$clog2(NSLOTS+1)-1:0]    busy_cnt
);

    localparam int CNT_W = $clog2(NSLOTS+1);

    logic [NSLOTS-1:0] occ_q, occ_d;
    logic [NSLOTS-1:0] fp_q, fp_d;
    logic [4:0]        rd_q  [NSLOTS];
    logic [4:0]        rd_d  [NSLOTS];
    logic [LAT_W-1:0]  cnt_q [NSLOTS];
    logic [LAT_W-1:0]  cnt_d [NSLOTS];
    logic [CNT_W-1:0]  busy_d;

    logic [NSLOTS-1:0] done;
    logic [NSLOTS-1:0] free_oh;
    logic [NSLOTS-1:0] wb_oh;
    logic              any_free;
    logic              any_done;
    logic              waw_block;
    logic              iss_fire;
    logic              wb_fire;
    logic [4:0]        wb_rd_sel;
    logic              wb_fp_sel;
    logic [LAT_W-1:0]  lat_eff;

    // Integer x0 is hardwired zero, so it can never be waited on.
    function automatic logic pending(input logic f, input logic [4:0] r);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (occ_q[i] && (fp_q[i] == f) && (rd_q[i] == r))
                hit = 1'b1;
        end
        if (!f && (r == 5'd0))
            hit = 1'b0;
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < NSLOTS; i++)
            done[i] = occ_q[i] && (cnt_q[i] == '0);
    end

    // Lowest-index isolation: lowest clear bit of occ, lowest set bit of done.
    assign free_oh  = ~occ_q & (occ_q + NSLOTS'(1));
    assign wb_oh    = done & (~done + NSLOTS'(1));
    assign any_free = ~&occ_q;
    assign any_done = |done;

    always_comb begin
        wb_rd_sel = 5'd0;
        wb_fp_sel = 1'b0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (wb_oh[i]) begin
                wb_rd_sel = wb_rd_sel | rd_q[i];
                wb_fp_sel = wb_fp_sel | fp_q[i];
            end
        end
    end

    assign hz = (rs_used[0] & pending(rs1_fp, rs1))
              | (rs_used[1] & pending(rs2_fp, rs2))
              | (rs_used[2] & pending(rs3_fp, rs3));

`ifdef FP_SCOREBOARD_WAW_CHECK_EN
    assign waw_block = pending(iss_rd_fp, iss_rd);
`else
    assign waw_block = 1'b0;
`endif

    assign iss_ready = any_free & ~hz & ~flush & ~Rst & ~waw_block;
    assign iss_fire  = iss_valid & iss_ready;
    assign wb_valid  = any_done & ~flush & ~Rst;
    assign wb_fire   = wb_valid & wb_ready;
    assign wb_rd     = wb_valid ? wb_rd_sel : 5'd0;
    assign wb_fp     = wb_valid & wb_fp_sel;
    assign lat_eff   = (iss_lat == '0) ? LAT_W'(1) : iss_lat;

    // A retiring slot is still occupied this cycle, so issue never lands on it.
    always_comb begin
        occ_d  = occ_q;
        fp_d   = fp_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        busy_d = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (flush) begin
                occ_d[i] = 1'b0;
                cnt_d[i] = '0;
            end else if (wb_fire && wb_oh[i]) begin
                occ_d[i] = 1'b0;
            end else if (iss_fire && free_oh[i]) begin
                occ_d[i] = 1'b1;
                rd_d[i]  = iss_rd;
                fp_d[i]  = iss_rd_fp;
                cnt_d[i] = lat_eff;
            end else if (occ_q[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - LAT_W'(1);
            end
        end
        for (int i = 0; i < NSLOTS; i++)
            busy_d = busy_d + CNT_W'(occ_d[i]);
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            occ_q    <= '0;
            fp_q     <= '0;
            busy_cnt <= '0;
            for (int i = 0; i < NSLOTS; i++) begin
                rd_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            occ_q    <= occ_d;
            fp_q     <= fp_d;
            busy_cnt <= busy_d;
            for (int i = 0; i < NSLOTS; i++) begin
                rd_q[i]  <= rd_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
